// File: rtl/softmax_avg_argmax_if.sv
// Handshake and int-res memory port bundle for the softmax averaging / argmax stage.
// master is the stage itself; slave is the step controller plus memory arbiter side.
interface softmax_avg_argmax_if #(
  parameter int N_DATA = 9,
  parameter int ADDR_W = 16
);
  logic              start;
  logic              busy;
  logic              done;
  logic [2:0]        sleep_stage;
  logic              mem_rd_en;
  logic              mem_wr_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [N_DATA-1:0] mem_wr_data;
  logic [N_DATA-1:0] mem_rd_data;

  modport master (
    input  start, mem_rd_data,
    output busy, done, sleep_stage, mem_rd_en, mem_wr_en, mem_addr, mem_wr_data
  );

  modport slave (
    output start, mem_rd_data,
    input  busy, done, sleep_stage, mem_rd_en, mem_wr_en, mem_addr, mem_wr_data
  );
endinterface

// File: rtl/softmax_avg_argmax.sv
// Final inference stage: sums the current softmax with up to NUM_AVG-1 stored vectors,
// picks the argmax class as the sleep stage, then shifts the stored history one slot older.
//
// state    | meaning
// IDLE     | waiting for start
// READ     | one memory read per cycle, class-major: cur[c], prev[0][c]..prev[hist_cnt-1][c]
// DRAIN    | last read datum arrives
// ARGMAX   | sums final; argmax registered into pend_stage
// RETIRE   | history writes, oldest destination slot first
// DONE     | done pulse, sleep_stage updated, hist_cnt advances
module softmax_avg_argmax #(
  parameter int NUM_CLASSES = 5,
  parameter int NUM_AVG     = 3,
  parameter int N_DATA      = 9,
  parameter int ADDR_W      = 16,
  parameter int CUR_BASE    = 32,
  parameter int PREV_BASE   = 57334
) (
  input  logic clk,
  input  logic rst,
  softmax_avg_argmax_if.master bus
);

  localparam int CW = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1;
  localparam int HW = (NUM_AVG > 1) ? $clog2(NUM_AVG) : 1;
  localparam int SW = N_DATA + $clog2(NUM_AVG);

  typedef enum logic [2:0] {
    S_IDLE, S_READ, S_DRAIN, S_ARGMAX, S_RETIRE, S_DONE
  } state_t;

  state_t              state;
  logic [HW-1:0]       hist_cnt;
  logic [HW-1:0]       slot;
  logic [HW-1:0]       rd_slot;
  logic [HW-1:0]       wr_slot;
  logic [HW-1:0]       wr_top;
  logic [CW-1:0]       cls;
  logic [CW-1:0]       rd_cls;
  logic [CW-1:0]       wr_cls;
  logic [CW-1:0]       pend_stage;
  logic [CW-1:0]       best_idx;
  logic                rd_vld;
  logic signed [SW-1:0] best_val;
  logic signed [N_DATA-1:0] rd_s;

  // arrays sized to the full index range so every index is exactly as wide as the array
  logic signed [SW-1:0] sums     [2**CW];
  logic [N_DATA-1:0]    cap_cur  [2**CW];
  logic [N_DATA-1:0]    cap_prev [2**HW][2**CW];

  assign rd_s   = bus.mem_rd_data;
  assign wr_top = (int'(hist_cnt) < NUM_AVG - 2) ? hist_cnt : HW'(NUM_AVG - 2);

  // strict greater-than keeps the lowest index on ties
  always_comb begin
    best_idx = '0;
    best_val = sums[0];
    for (int c = 1; c < NUM_CLASSES; c++) begin
      if (sums[c] > best_val) begin
        best_val = sums[c];
        best_idx = CW'(c);
      end
    end
  end

  function automatic logic [ADDR_W-1:0] prev_addr(input logic [HW-1:0] k, input logic [CW-1:0] c);
    return ADDR_W'(PREV_BASE + int'(k) * NUM_CLASSES + int'(c));
  endfunction

  function automatic logic [ADDR_W-1:0] rd_addr(input logic [HW-1:0] k, input logic [CW-1:0] c);
    if (k == '0) return ADDR_W'(CUR_BASE + int'(c));
    return prev_addr(k - 1'b1, c);
  endfunction

  function automatic logic [N_DATA-1:0] wr_src(input logic [HW-1:0] d, input logic [CW-1:0] c);
    if (d == '0) return cap_cur[c];
    return cap_prev[d - 1'b1][c];
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= S_IDLE;
      bus.busy        <= 1'b0;
      bus.done        <= 1'b0;
      bus.sleep_stage <= '0;
      bus.mem_rd_en   <= 1'b0;
      bus.mem_wr_en   <= 1'b0;
      bus.mem_addr    <= '0;
      bus.mem_wr_data <= '0;
      hist_cnt        <= '0;
      slot            <= '0;
      cls             <= '0;
      rd_vld          <= 1'b0;
      rd_slot         <= '0;
      rd_cls          <= '0;
      wr_slot         <= '0;
      wr_cls          <= '0;
      pend_stage      <= '0;
      for (int i = 0; i < 2**CW; i++) begin
        sums[i]    <= '0;
        cap_cur[i] <= '0;
        for (int k = 0; k < 2**HW; k++) cap_prev[k][i] <= '0;
      end
    end else begin
      // read data returns one cycle after its request
      rd_vld  <= bus.mem_rd_en;
      rd_slot <= slot;
      rd_cls  <= cls;
      if (rd_vld) begin
        sums[rd_cls] <= sums[rd_cls] + SW'(rd_s);
        if (rd_slot == '0)
          cap_cur[rd_cls] <= bus.mem_rd_data;
        else if (int'(rd_slot) <= NUM_AVG - 2)
          cap_prev[rd_slot - 1'b1][rd_cls] <= bus.mem_rd_data;
      end

      case (state)
        S_IDLE: begin
          if (bus.start) begin
            state         <= S_READ;
            bus.busy      <= 1'b1;
            bus.mem_rd_en <= 1'b1;
            bus.mem_addr  <= rd_addr('0, '0);
            slot          <= '0;
            cls           <= '0;
            for (int i = 0; i < 2**CW; i++) sums[i] <= '0;
          end
        end
        S_READ: begin
          if (cls == CW'(NUM_CLASSES - 1) && slot == hist_cnt) begin
            bus.mem_rd_en <= 1'b0;
            state         <= S_DRAIN;
          end else if (slot == hist_cnt) begin
            slot         <= '0;
            cls          <= cls + 1'b1;
            bus.mem_addr <= rd_addr('0, cls + 1'b1);
          end else begin
            slot         <= slot + 1'b1;
            bus.mem_addr <= rd_addr(slot + 1'b1, cls);
          end
        end
        S_DRAIN: state <= S_ARGMAX;
        S_ARGMAX: begin
          pend_stage <= best_idx;
          if (NUM_AVG > 1) begin
            state           <= S_RETIRE;
            bus.mem_wr_en   <= 1'b1;
            wr_slot         <= wr_top;
            wr_cls          <= '0;
            bus.mem_addr    <= prev_addr(wr_top, '0);
            bus.mem_wr_data <= wr_src(wr_top, '0);
          end else begin
            state           <= S_DONE;
            bus.done        <= 1'b1;
            bus.sleep_stage <= 3'(best_idx);
          end
        end
        S_RETIRE: begin
          if (wr_slot == '0 && wr_cls == CW'(NUM_CLASSES - 1)) begin
            bus.mem_wr_en   <= 1'b0;
            bus.done        <= 1'b1;
            bus.sleep_stage <= 3'(pend_stage);
            state           <= S_DONE;
          end else if (wr_cls == CW'(NUM_CLASSES - 1)) begin
            wr_slot         <= wr_slot - 1'b1;
            wr_cls          <= '0;
            bus.mem_addr    <= prev_addr(wr_slot - 1'b1, '0);
            bus.mem_wr_data <= wr_src(wr_slot - 1'b1, '0);
          end else begin
            wr_cls          <= wr_cls + 1'b1;
            bus.mem_addr    <= prev_addr(wr_slot, wr_cls + 1'b1);
            bus.mem_wr_data <= wr_src(wr_slot, wr_cls + 1'b1);
          end
        end
        S_DONE: begin
          bus.done <= 1'b0;
          bus.busy <= 1'b0;
          if (int'(hist_cnt) < NUM_AVG - 1) hist_cnt <= hist_cnt + 1'b1;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_softmax_avg_argmax.sv
// Directed bench for softmax_avg_argmax: int-res memory model, per-scenario tasks
// with hand-computed sums, argmax, history contents and cycle latencies.
module tb_softmax_avg_argmax;

  localparam int CUR = 32;
  localparam int S0  = 57334;
  localparam int S1  = 57339;

  logic clk;
  logic rst;
  softmax_avg_argmax_if bus ();

  softmax_avg_argmax dut (.clk(clk), .rst(rst), .bus(bus));

  int ncmp = 0;
  int nfail = 0;
  int cyc = 0;
  int rd_cnt = 0;
  int wr_cnt = 0;
  int both_cnt = 0;
  int done_cnt = 0;

  logic [8:0] mem [65536];
  int cur_v [5];
  int s0_v [5];
  int s1_v [5];
  bit ld_req = 0;
  bit ld_prev = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // memory model: one-cycle read latency, plus a backdoor loader owned by this process
  always @(posedge clk) begin
    if (ld_req) begin
      for (int i = 0; i < 5; i++) begin
        mem[CUR + i] <= 9'(cur_v[i]);
        if (ld_prev) begin
          mem[S0 + i] <= 9'(s0_v[i]);
          mem[S1 + i] <= 9'(s1_v[i]);
        end
      end
    end
    if (bus.mem_rd_en) bus.mem_rd_data <= mem[bus.mem_addr];
    if (bus.mem_wr_en) mem[bus.mem_addr] <= bus.mem_wr_data;
  end

  always @(negedge clk) begin
    if (bus.mem_rd_en === 1'b1) rd_cnt++;
    if (bus.mem_wr_en === 1'b1) wr_cnt++;
    if (bus.mem_rd_en === 1'b1 && bus.mem_wr_en === 1'b1) both_cnt++;
    if (bus.done === 1'b1) done_cnt++;
  end

  task automatic load(input bit prev);
    ld_prev = prev;
    ld_req = 1'b1;
    @(posedge clk); #1;
    ld_req = 1'b0;
    ld_prev = 1'b0;
  endtask

  task automatic run_op(input bit extra, input bit at_done, output int lat, output int nrd, output int nwr);
    int s, r0, w0;
    bit got;
    r0 = rd_cnt;
    w0 = wr_cnt;
    got = 1'b0;
    lat = -1;
    @(posedge clk); #1;
    bus.start = 1'b1;
    s = cyc;
    for (int k = 1; k < 200 && !got; k++) begin
      @(posedge clk); #1;
      bus.start = extra && (k == 3 || k == 10);
      @(negedge clk);
      if (k == 1) begin
        ncmp++;
        if (bus.busy !== 1'b1) begin
          nfail++;
          $display("FAIL busy_after_start: got %b want 1", bus.busy);
        end
      end
      if (bus.done === 1'b1) begin
        got = 1'b1;
        lat = cyc - s;
      end
    end
    if (at_done && got) begin
      bus.start = 1'b1;
      @(posedge clk); #1;
    end
    bus.start = 1'b0;
    if (!got) begin
      ncmp++;
      nfail++;
      $display("FAIL op_timeout: no done within 200 cycles");
    end
    nrd = rd_cnt - r0;
    nwr = wr_cnt - w0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    ncmp++; if (bus.busy !== 1'b0) begin nfail++; $display("FAIL rst_busy: got %b want 0", bus.busy); end
    ncmp++; if (bus.done !== 1'b0) begin nfail++; $display("FAIL rst_done: got %b want 0", bus.done); end
    ncmp++; if (bus.sleep_stage !== 3'd0) begin nfail++; $display("FAIL rst_stage: got %0d want 0", bus.sleep_stage); end
    ncmp++; if (bus.mem_rd_en !== 1'b0) begin nfail++; $display("FAIL rst_rd_en: got %b want 0", bus.mem_rd_en); end
    ncmp++; if (bus.mem_wr_en !== 1'b0) begin nfail++; $display("FAIL rst_wr_en: got %b want 0", bus.mem_wr_en); end
    ncmp++; if (bus.mem_addr !== 16'd0) begin nfail++; $display("FAIL rst_addr: got %h want 0", bus.mem_addr); end
    ncmp++; if (bus.mem_wr_data !== 9'd0) begin nfail++; $display("FAIL rst_wr_data: got %h want 0", bus.mem_wr_data); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_first();
    int lat, nrd, nwr;
    int e [5] = '{10, 50, 20, 5, 15};
    for (int i = 0; i < 5; i++) cur_v[i] = e[i];
    load(1'b0);
    run_op(1'b0, 1'b0, lat, nrd, nwr);
    ncmp++; if (lat !== 13) begin nfail++; $display("FAIL first_latency: got %0d want 13", lat); end
    ncmp++; if (nrd !== 5) begin nfail++; $display("FAIL first_reads: got %0d want 5", nrd); end
    ncmp++; if (nwr !== 5) begin nfail++; $display("FAIL first_writes: got %0d want 5", nwr); end
    ncmp++; if (bus.sleep_stage !== 3'd1) begin nfail++; $display("FAIL first_stage: got %0d want 1", bus.sleep_stage); end
    for (int i = 0; i < 5; i++) begin
      ncmp++;
      if (mem[S0 + i] !== 9'(e[i])) begin nfail++; $display("FAIL first_slot0[%0d]: got %0d want %0d", i, mem[S0 + i], e[i]); end
    end
  endtask

  task automatic test_second();
    int lat, nrd, nwr;
    int c [5] = '{1, 2, 3, 4, 100};
    int o [5] = '{10, 50, 20, 5, 15};
    for (int i = 0; i < 5; i++) cur_v[i] = c[i];
    load(1'b0);
    run_op(1'b0, 1'b0, lat, nrd, nwr);
    ncmp++; if (lat !== 23) begin nfail++; $display("FAIL second_latency: got %0d want 23", lat); end
    ncmp++; if (nrd !== 10) begin nfail++; $display("FAIL second_reads: got %0d want 10", nrd); end
    ncmp++; if (nwr !== 10) begin nfail++; $display("FAIL second_writes: got %0d want 10", nwr); end
    ncmp++; if (bus.sleep_stage !== 3'd4) begin nfail++; $display("FAIL second_stage: got %0d want 4", bus.sleep_stage); end
    for (int i = 0; i < 5; i++) begin
      ncmp++;
      if (mem[S1 + i] !== 9'(o[i]) || mem[S0 + i] !== 9'(c[i])) begin
        nfail++;
        $display("FAIL second_hist[%0d]: got s1=%0d s0=%0d want s1=%0d s0=%0d", i, mem[S1 + i], mem[S0 + i], o[i], c[i]);
      end
    end
  endtask

  task automatic test_steady();
    int lat, nrd, nwr;
    int c [5] = '{10, 0, 0, 0, 0};
    int p0 [5] = '{0, 30, 0, 0, 0};
    int p1 [5] = '{0, 0, 0, 0, 25};
    for (int i = 0; i < 5; i++) begin cur_v[i] = c[i]; s0_v[i] = p0[i]; s1_v[i] = p1[i]; end
    load(1'b1);
    run_op(1'b0, 1'b0, lat, nrd, nwr);
    ncmp++; if (lat !== 28) begin nfail++; $display("FAIL steady_latency: got %0d want 28", lat); end
    ncmp++; if (nrd !== 15) begin nfail++; $display("FAIL steady_reads: got %0d want 15", nrd); end
    ncmp++; if (nwr !== 10) begin nfail++; $display("FAIL steady_writes: got %0d want 10", nwr); end
    ncmp++; if (bus.sleep_stage !== 3'd1) begin nfail++; $display("FAIL steady_stage: got %0d want 1", bus.sleep_stage); end
    for (int i = 0; i < 5; i++) begin
      ncmp++;
      if (mem[S1 + i] !== 9'(p0[i]) || mem[S0 + i] !== 9'(c[i])) begin
        nfail++;
        $display("FAIL steady_hist[%0d]: got s1=%0d s0=%0d want s1=%0d s0=%0d", i, mem[S1 + i], mem[S0 + i], p0[i], c[i]);
      end
    end
  endtask

  task automatic test_tie();
    int lat, nrd, nwr;
    int c [5] = '{20, 10, 5, 5, 0};
    int p0 [5] = '{10, 20, 5, 5, 0};
    int p1 [5] = '{10, 10, 0, 0, 0};
    for (int i = 0; i < 5; i++) begin cur_v[i] = c[i]; s0_v[i] = p0[i]; s1_v[i] = p1[i]; end
    load(1'b1);
    run_op(1'b0, 1'b0, lat, nrd, nwr);
    ncmp++; if (bus.sleep_stage !== 3'd0) begin nfail++; $display("FAIL tie_stage: got %0d want 0", bus.sleep_stage); end
  endtask

  task automatic test_no_wrap();
    int lat, nrd, nwr;
    for (int i = 0; i < 5; i++) begin
      cur_v[i] = (i == 4) ? 255 : 0;
      s0_v[i] = cur_v[i];
      s1_v[i] = cur_v[i];
    end
    load(1'b1);
    run_op(1'b0, 1'b0, lat, nrd, nwr);
    ncmp++; if (bus.sleep_stage !== 3'd4) begin nfail++; $display("FAIL nowrap_stage: got %0d want 4", bus.sleep_stage); end
    for (int i = 0; i < 5; i++) begin cur_v[i] = 255; s0_v[i] = 255; s1_v[i] = 255; end
    load(1'b1);
    run_op(1'b0, 1'b0, lat, nrd, nwr);
    ncmp++; if (bus.sleep_stage !== 3'd0) begin nfail++; $display("FAIL max_stage: got %0d want 0", bus.sleep_stage); end
  endtask

  task automatic test_ignore_start();
    int lat, nrd, nwr, r1, d0;
    for (int i = 0; i < 5; i++) begin cur_v[i] = (i == 2) ? 7 : 0; s0_v[i] = 0; s1_v[i] = 0; end
    load(1'b1);
    d0 = done_cnt;
    run_op(1'b1, 1'b1, lat, nrd, nwr);
    r1 = rd_cnt;
    ncmp++; if (lat !== 28) begin nfail++; $display("FAIL ignore_latency: got %0d want 28", lat); end
    ncmp++; if (nrd !== 15) begin nfail++; $display("FAIL ignore_reads: got %0d want 15", nrd); end
    ncmp++; if (nwr !== 10) begin nfail++; $display("FAIL ignore_writes: got %0d want 10", nwr); end
    ncmp++; if (bus.sleep_stage !== 3'd2) begin nfail++; $display("FAIL ignore_stage: got %0d want 2", bus.sleep_stage); end
    repeat (5) @(negedge clk);
    ncmp++; if (bus.busy !== 1'b0) begin nfail++; $display("FAIL start_at_done_busy: got %b want 0", bus.busy); end
    ncmp++; if (rd_cnt !== r1) begin nfail++; $display("FAIL start_at_done_reads: got %0d want %0d", rd_cnt, r1); end
    ncmp++; if (done_cnt - d0 !== 1) begin nfail++; $display("FAIL ignore_done_count: got %0d want 1", done_cnt - d0); end
    ncmp++; if (both_cnt !== 0) begin nfail++; $display("FAIL rd_wr_overlap: got %0d want 0", both_cnt); end
  endtask

  task automatic test_reset_mid();
    bit seen;
    for (int i = 0; i < 5; i++) begin cur_v[i] = (i == 4) ? 9 : 1; s0_v[i] = 0; s1_v[i] = 0; end
    load(1'b1);
    @(posedge clk); #1;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 100 && !seen; k++) begin
      @(negedge clk);
      if (bus.mem_wr_en === 1'b1) seen = 1'b1;
    end
    if (!seen) begin
      ncmp++; nfail++;
      $display("FAIL retire_timeout: no write within 100 cycles");
    end
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    ncmp++;
    if ({bus.busy, bus.done, bus.sleep_stage, bus.mem_rd_en, bus.mem_wr_en, bus.mem_addr, bus.mem_wr_data} !== 32'd0) begin
      nfail++;
      $display("FAIL midreset_outputs: got busy=%b done=%b stage=%0d rd=%b wr=%b addr=%h data=%h want all 0",
               bus.busy, bus.done, bus.sleep_stage, bus.mem_rd_en, bus.mem_wr_en, bus.mem_addr, bus.mem_wr_data);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_negative();
    int lat, nrd, nwr;
    int c [5] = '{-5, -3, -9, -4, -8};
    for (int i = 0; i < 5; i++) cur_v[i] = c[i];
    load(1'b0);
    run_op(1'b0, 1'b0, lat, nrd, nwr);
    ncmp++; if (lat !== 13) begin nfail++; $display("FAIL neg_latency: got %0d want 13", lat); end
    ncmp++; if (nrd !== 5) begin nfail++; $display("FAIL neg_reads: got %0d want 5", nrd); end
    ncmp++; if (nwr !== 5) begin nfail++; $display("FAIL neg_writes: got %0d want 5", nwr); end
    ncmp++; if (bus.sleep_stage !== 3'd1) begin nfail++; $display("FAIL neg_stage: got %0d want 1", bus.sleep_stage); end
    ncmp++; if (mem[S0 + 2] !== 9'h1F7) begin nfail++; $display("FAIL neg_slot0: got %h want 1f7", mem[S0 + 2]); end
  endtask

  initial begin
    rst = 1'b1;
    bus.start = 1'b0;
    test_reset();
    test_first();
    test_second();
    test_steady();
    test_tie();
    test_no_wrap();
    test_ignore_start();
    test_reset_mid();
    test_negative();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
